// File: rtl/mem_bus_interface_pkg.sv
// mem_bus_interface_pkg: state encodings and constants shared by the pad bus sequencer
package mem_bus_interface_pkg;
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ADDR_HI = 3'd1,
      ADDR_LO = 3'd2,
      DATA    = 3'd3,
      RESP    = 3'd4
   } state_t;
   localparam logic [7:0] RSP_ERR_DATA = 8'hFF;
   localparam int WAIT_MAX_DEF = 15;
endpackage

// File: rtl/mem_bus_interface_if.sv
// mem_bus_interface_if: core request/response and pad-side signals of the memory bus sequencer
interface mem_bus_interface_if;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_addr;
   logic        req_we;
   logic [7:0]  req_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;
   logic [7:0]  pad_addr_out;
   logic        pad_ale_hi;
   logic        pad_ale_lo;
   logic        pad_rw;
   logic        pad_strobe;
   logic [7:0]  pad_data_out;
   logic [7:0]  pad_data_oe;
   logic [7:0]  pad_data_in;
   logic        pad_wait;
   modport master (
      output req_valid, req_addr, req_we, req_wdata, pad_data_in, pad_wait,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, pad_addr_out, pad_ale_hi,
             pad_ale_lo, pad_rw, pad_strobe, pad_data_out, pad_data_oe
   );
   modport slave (
      input  req_valid, req_addr, req_we, req_wdata, pad_data_in, pad_wait,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, pad_addr_out, pad_ale_hi,
             pad_ale_lo, pad_rw, pad_strobe, pad_data_out, pad_data_oe
   );
endinterface

// File: rtl/membus_wait_timer.sv
// membus_wait_timer: saturating wait-state counter, expired once WAIT_MAX waits have been counted
module membus_wait_timer
   import mem_bus_interface_pkg::*;
#(
   parameter int WAIT_MAX = WAIT_MAX_DEF,
   parameter int WAIT_W   = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic count,
   output logic expired
);
   logic [WAIT_W-1:0] cnt;
   always_ff @(posedge clk) begin
      if (!rst_n || clear) cnt <= '0;
      else if (count && cnt != '1) cnt <= cnt + WAIT_W'(1);
   end
   assign expired = cnt == WAIT_W'(WAIT_MAX);
endmodule

// File: rtl/mem_bus_interface.sv
// mem_bus_interface: sequences one access as addr-hi / addr-lo / data phases on the 8-bit pad bus.
// Optional MEMBUS_HI_SKIP_EN skips the addr-hi phase when the high byte matches the last good access.
module mem_bus_interface
   import mem_bus_interface_pkg::*;
#(
   parameter int WAIT_MAX = WAIT_MAX_DEF,
   parameter int WAIT_W   = 8
) (
   input logic clk,
   input logic rst_n,
   mem_bus_interface_if.slave bus
);
   state_t      state, next;
   logic [15:0] addr_q;
   logic        we_q;
   logic [7:0]  wdata_q;
   logic [7:0]  rdata_q;
   logic        err_q;
   logic        expired;
   logic        done;
   logic        skip;
   logic        is_data;
   assign done    = state == DATA && (!bus.pad_wait || expired);
   assign is_data = rst_n && state == DATA;
   membus_wait_timer #(.WAIT_MAX(WAIT_MAX), .WAIT_W(WAIT_W)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (state == RESP),
      .count   (state == DATA && bus.pad_wait && !expired),
      .expired (expired)
   );
`ifdef MEMBUS_HI_SKIP_EN
   logic [7:0] last_hi;
   logic       hi_valid;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_hi  <= 8'h00;
         hi_valid <= 1'b0;
      end else if (done) begin
         hi_valid <= !bus.pad_wait;
         if (!bus.pad_wait) last_hi <= addr_q[15:8];
      end
   end
   assign skip = hi_valid && bus.req_addr[15:8] == last_hi;
`else
   assign skip = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else state <= next;
   end
   always_comb begin
      next = state;
      case (state)
         IDLE:    if (bus.req_valid) next = skip ? ADDR_LO : ADDR_HI;
         ADDR_HI: next = ADDR_LO;
         ADDR_LO: next = DATA;
         DATA:    if (!bus.pad_wait || expired) next = RESP;
         default: next = IDLE;
      endcase
   end
   // a done cycle with pad_wait still high can only be the timeout
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q  <= 16'h0000;
         we_q    <= 1'b0;
         wdata_q <= 8'h00;
         rdata_q <= 8'h00;
         err_q   <= 1'b0;
      end else begin
         if (state == IDLE && bus.req_valid) begin
            addr_q  <= bus.req_addr;
            we_q    <= bus.req_we;
            wdata_q <= bus.req_we ? bus.req_wdata : 8'h00;
         end
         if (done) begin
            rdata_q <= we_q ? 8'h00 : bus.pad_wait ? RSP_ERR_DATA : bus.pad_data_in;
            err_q   <= bus.pad_wait;
         end
      end
   end
   assign bus.req_ready    = rst_n && state == IDLE;
   assign bus.rsp_valid    = rst_n && state == RESP;
   assign bus.rsp_rdata    = rst_n ? rdata_q : 8'h00;
   assign bus.rsp_err      = rst_n && err_q;
   assign bus.pad_ale_hi   = rst_n && state == ADDR_HI;
   assign bus.pad_ale_lo   = rst_n && state == ADDR_LO;
   assign bus.pad_strobe   = is_data;
   assign bus.pad_rw       = !(is_data && we_q);
   assign bus.pad_addr_out = !rst_n ? 8'h00 : state == ADDR_HI ? addr_q[15:8] :
                             (state == ADDR_LO || state == DATA) ? addr_q[7:0] : 8'h00;
   assign bus.pad_data_out = (is_data && we_q) ? wdata_q : 8'h00;
   assign bus.pad_data_oe  = {8{is_data && we_q}};
endmodule

// File: tb/tb_mem_bus_interface.sv
// tb_mem_bus_interface: directed and randomized accesses checked against a phase-level model of the bus
module tb_mem_bus_interface;
   localparam int WAIT_MAX = 15;
`ifdef MEMBUS_HI_SKIP_EN
   localparam bit SKIP_EN = 1'b1;
`else
   localparam bit SKIP_EN = 1'b0;
`endif
   logic clk;
   logic rst_n;
   int   n_run;
   int   n_fail;
   logic       m_hi_valid;
   logic [7:0] m_last_hi;
   mem_bus_interface_if bus ();
   mem_bus_interface #(.WAIT_MAX(WAIT_MAX), .WAIT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   function automatic logic [29:0] pv();
      return {bus.req_ready, bus.rsp_valid, bus.pad_ale_hi, bus.pad_ale_lo, bus.pad_strobe,
              bus.pad_rw, bus.pad_addr_out, bus.pad_data_out, bus.pad_data_oe};
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // One access: latency and per-cycle pad values follow from the phase rules alone
   task automatic access(input logic [15:0] a, input logic we, input logic [7:0] wd,
                         input int nw, input logic [7:0] din, input bit hold);
      bit         skip;
      bit         to;
      int         nd;
      int         lat;
      int         d;
      logic [7:0] er;
      logic [29:0] v;
      skip = SKIP_EN && m_hi_valid && a[15:8] == m_last_hi;
      to   = nw > WAIT_MAX;
      nd   = to ? WAIT_MAX + 1 : nw + 1;
      lat  = (skip ? 2 : 3) + nd;
      er   = we ? 8'h00 : to ? 8'hFF : din;
      bus.req_valid   = 1'b1;
      bus.req_addr    = a;
      bus.req_we      = we;
      bus.req_wdata   = wd;
      bus.pad_data_in = din;
      bus.pad_wait    = 1'b0;
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         v = pv();
         d = k - (skip ? 2 : 3);
         if (k == lat) begin
            chk("resp_ctl", {v[29:24], v[15:0]}, {6'b010001, 16'h0000});
            chk("resp_rdata", bus.rsp_rdata, er);
            chk("resp_err", bus.rsp_err, to);
            bus.pad_wait = 1'b0;
            if (!hold) bus.req_valid = 1'b0;
         end else if (d >= 0) begin
            chk("data", v, {5'b00001, ~we, a[7:0], we ? wd : 8'h00, we ? 8'hFF : 8'h00});
            bus.pad_wait = to || d < nw;
         end else if (k == 1 && !skip) begin
            chk("addr_hi", v, {6'b001001, a[15:8], 16'h0000});
         end else begin
            chk("addr_lo", v, {6'b000101, a[7:0], 16'h0000});
         end
      end
      @(negedge clk);
      chk("idle", pv(), {6'b100001, 24'h0});
      chk("hold_rdata", bus.rsp_rdata, er);
      chk("hold_err", bus.rsp_err, to);
      m_hi_valid = !to;
      if (!to) m_last_hi = a[15:8];
   endtask
   initial begin
      int ktd;
      int nw;
      n_run = 0;
      n_fail = 0;
      m_hi_valid = 1'b0;
      m_last_hi = 8'h00;
      rst_n = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_addr = 16'h0000;
      bus.req_we = 1'b0;
      bus.req_wdata = 8'h00;
      bus.pad_data_in = 8'h00;
      bus.pad_wait = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_pads", pv(), {6'b000001, 24'h0});
      chk("reset_rdata", bus.rsp_rdata, 8'h00);
      chk("reset_err", bus.rsp_err, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_idle", pv(), {6'b100001, 24'h0});
      access(16'h12A5, 1'b0, 8'h00, 0, 8'h3C, 1'b0);
      access(16'h0200, 1'b1, 8'h7E, 2, 8'hC3, 1'b0);
      access(16'h5555, 1'b0, 8'h00, 99, 8'h11, 1'b0);
      access(16'h3401, 1'b0, 8'h00, 0, 8'hA1, 1'b0);
      access(16'h3402, 1'b0, 8'h00, 0, 8'hA2, 1'b0);
      access(16'h3480, 1'b0, 8'h00, 99, 8'hA3, 1'b0);
      access(16'h3403, 1'b0, 8'h00, 1, 8'hA4, 1'b0);
      access(16'h1001, 1'b0, 8'h00, 0, 8'h01, 1'b1);
      access(16'h2002, 1'b0, 8'h00, 0, 8'h02, 1'b1);
      access(16'h3003, 1'b0, 8'h00, 0, 8'h03, 1'b0);
      ktd = (SKIP_EN && m_hi_valid && m_last_hi == 8'h02) ? 2 : 3;
      bus.req_valid = 1'b1;
      bus.req_addr = 16'h0200;
      bus.req_we = 1'b1;
      bus.req_wdata = 8'h55;
      repeat (ktd) @(negedge clk);
      chk("rst_data", pv(), {6'b000010, 8'h00, 8'h55, 8'hFF});
      bus.req_valid = 1'b0;
      bus.pad_wait = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_abort_pads", pv(), {6'b000001, 24'h0});
      chk("rst_abort_rdata", bus.rsp_rdata, 8'h00);
      rst_n = 1'b1;
      bus.pad_wait = 1'b0;
      m_hi_valid = 1'b0;
      @(negedge clk);
      chk("rst_after_idle", pv(), {6'b100001, 24'h0});
      @(negedge clk);
      chk("rst_no_rsp", bus.rsp_valid, 1'b0);
      for (int i = 0; i < 24; i++) begin
         nw = ($urandom_range(0, 7) == 0) ? 99 : int'($urandom_range(0, 3));
         access({($urandom_range(0, 1) == 1) ? 8'h34 : 8'($urandom), 8'($urandom)},
                1'($urandom_range(0, 1)), 8'($urandom), nw, 8'($urandom), 1'b0);
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
